// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset (lw/sw/beq/addi/add/sub/and/or/slt, optional j) with one
// shared memory port. Define MIPS_JUMP_EN to enable j; otherwise opcode 02h halts as illegal.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          ZERO_WAIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] pc_dbg
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB,
    ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q, addr_q, wdata_q;
  logic        req_q, we_q, first_q, halted_q, illegal_q;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx, rs_val, rt_val, jmp_tgt, rt_alu_d;
  logic        ack_ok, funct_ok;

  assign op      = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign imm_sx  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign jmp_tgt = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign rs_val  = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rt_val  = (rt == 5'd0) ? 32'h0 : rf[rt];

  // Ack only counts while a request is up; without ZERO_WAIT the first cycle is skipped.
  assign ack_ok   = req_q & mem_ack & (ZERO_WAIT | ~first_q);
  assign funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                    (funct == 6'h25) || (funct == 6'h2A);

  always_comb begin
    rt_alu_d = 32'h0;
    case (funct)
      6'h20:   rt_alu_d = a_q + b_q;
      6'h22:   rt_alu_d = a_q - b_q;
      6'h24:   rt_alu_d = a_q & b_q;
      6'h25:   rt_alu_d = a_q | b_q;
      6'h2A:   rt_alu_d = {31'h0, $signed(a_q) < $signed(b_q)};
      default: rt_alu_d = 32'h0;
    endcase
  end

  // States that end an instruction launch the next fetch directly, so FETCH has req up on entry.
  logic        fetch_go_d;
  logic [31:0] fetch_pc_d;
  always_comb begin
    fetch_go_d = 1'b0;
    fetch_pc_d = pc_q;
    case (state_q)
      MEMWB, RTWB, ADDIWB: fetch_go_d = 1'b1;
      MEMWR:               fetch_go_d = ack_ok;
      BRANCH: begin
        fetch_go_d = 1'b1;
        fetch_pc_d = (a_q == b_q) ? alu_q : pc_q;
      end
      JUMP: begin
        fetch_go_d = 1'b1;
        fetch_pc_d = jmp_tgt;
      end
      default: ;
    endcase
  end

  logic        rf_we_d;
  logic [4:0]  rf_wa_d;
  logic [31:0] rf_wd_d;
  always_comb begin
    rf_we_d = 1'b0;
    rf_wa_d = rt;
    rf_wd_d = alu_q;
    case (state_q)
      MEMWB:  begin rf_we_d = 1'b1; rf_wd_d = mdr_q; end
      RTWB:   begin rf_we_d = 1'b1; rf_wa_d = rd;    end
      ADDIWB: rf_we_d = 1'b1;
      default: ;
    endcase
  end

  // Register file survives reset; r0 is never written.
  always_ff @(posedge CLK) begin
    if (rf_we_d && rf_wa_d != 5'd0) rf[rf_wa_d] <= rf_wd_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_q     <= 32'h0;
      mdr_q     <= 32'h0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      first_q   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_q   <= 1'b1;
            first_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= pc_q;
          end else if (ack_ok) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 32'd4;
            req_q   <= 1'b0;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          a_q   <= rs_val;
          b_q   <= rt_val;
          alu_q <= pc_q + {imm_sx[29:0], 2'b00};
          case (op)
            6'h23, 6'h2B: state_q <= MEMADR;
            6'h00: begin
              if (funct_ok) state_q <= RTEX;
              else begin
                state_q   <= HALT;
                halted_q  <= 1'b1;
                illegal_q <= 1'b1;
              end
            end
            6'h08: state_q <= ADDIEX;
            6'h04: state_q <= BRANCH;
`ifdef MIPS_JUMP_EN
            6'h02: state_q <= JUMP;
`endif
            default: begin
              state_q   <= HALT;
              halted_q  <= 1'b1;
              illegal_q <= 1'b1;
            end
          endcase
        end
        MEMADR: begin
          alu_q   <= a_q + imm_sx;
          addr_q  <= a_q + imm_sx;
          wdata_q <= b_q;
          we_q    <= (op == 6'h2B);
          req_q   <= 1'b1;
          first_q <= 1'b1;
          state_q <= (op == 6'h2B) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          if (ack_ok) begin
            mdr_q   <= mem_rdata;
            req_q   <= 1'b0;
            state_q <= MEMWB;
          end
        end
        RTEX:    begin alu_q <= rt_alu_d;       state_q <= RTWB;   end
        ADDIEX:  begin alu_q <= a_q + imm_sx;   state_q <= ADDIWB; end
        default: ;
      endcase
      if (fetch_go_d) begin
        state_q <= FETCH;
        pc_q    <= fetch_pc_d;
        addr_q  <= fetch_pc_d;
        we_q    <= 1'b0;
        req_q   <= 1'b1;
        first_q <= 1'b1;
      end
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign pc_dbg    = pc_q;
endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: random wait-state memory plus an instruction-level model
// that predicts every memory transaction, its cycle and pc_dbg, and the halt flags.
module tb_mips_multicycle;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] ILL    = 32'hFC00_0000;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        mem_req, mem_we, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, pc_dbg;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 CLK = ~CLK;

  mips_multicycle dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .halted(halted), .illegal(illegal), .pc_dbg(pc_dbg)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] pc; } tx_t;
  tx_t obs[$], expq[$];
  logic [31:0] bmem [256], mmem [256], mreg [32], prog [32];
  int waits [1024];
  int tidx = 0, wcnt = 0, cyc = 0, viol = 0;
  bit spur_en = 0, exp_halt;
  logic [31:0] h_addr, h_wd;
  logic        h_we;

  always @(posedge CLK) cyc = RST ? 0 : cyc + 1;

  // Memory responder: per-transaction wait count, optional junk acks while idle.
  always @(negedge CLK) begin
    if (RST) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_req) begin
      if (wcnt == 0) begin h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata; end
      else if ({mem_addr, mem_we, mem_wdata} !== {h_addr, h_we, h_wd}) viol++;
      if (wcnt >= waits[tidx]) begin
        mem_ack   = 1'b1;
        mem_rdata = bmem[mem_addr[9:2]];
        if (mem_we) bmem[mem_addr[9:2]] = mem_wdata;
        obs.push_back('{cyc, mem_we, mem_addr, mem_we ? mem_wdata : 32'h0, pc_dbg});
        tidx = (tidx + 1) % 1024;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack   = spur_en ? 1'($urandom % 2) : 1'b0;
      mem_rdata = $urandom;
      wcnt = 0;
    end
  end

  function automatic logic [31:0] sx(input logic [15:0] i);
    return {{16{i[15]}}, i};
  endfunction

  // Instruction-level model: walks the program and lists the expected bus transactions.
  task automatic model_run(input int max_tx);
    logic [31:0] pc, ir, npc, a, b, ad;
    int t, k, acc;
    bit done;
    expq.delete();
    exp_halt = 0; pc = RST_PC; t = 1; k = 0; done = 0;
    while (!done && expq.size() < max_tx) begin
      acc = t + waits[k % 1024]; k++;
      expq.push_back('{acc, 1'b0, pc, 32'h0, pc});
      ir = mmem[pc[9:2]]; npc = pc + 4;
      a = mreg[ir[25:21]]; b = mreg[ir[20:16]];
      case (ir[31:26])
        6'h23: begin
          ad = a + sx(ir[15:0]); acc = acc + 3 + waits[k % 1024]; k++;
          expq.push_back('{acc, 1'b0, ad, 32'h0, npc});
          mreg[ir[20:16]] = mmem[ad[9:2]]; t = acc + 2;
        end
        6'h2B: begin
          ad = a + sx(ir[15:0]); acc = acc + 3 + waits[k % 1024]; k++;
          expq.push_back('{acc, 1'b1, ad, b, npc});
          mmem[ad[9:2]] = b; t = acc + 1;
        end
        6'h00: begin
          t = acc + 4;
          case (ir[5:0])
            6'h20: mreg[ir[15:11]] = a + b;
            6'h22: mreg[ir[15:11]] = a - b;
            6'h24: mreg[ir[15:11]] = a & b;
            6'h25: mreg[ir[15:11]] = a | b;
            6'h2A: mreg[ir[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin done = 1; exp_halt = 1; end
          endcase
        end
        6'h08: begin mreg[ir[20:16]] = a + sx(ir[15:0]); t = acc + 4; end
        6'h04: begin if (a == b) npc = npc + (sx(ir[15:0]) << 2); t = acc + 3; end
`ifdef MIPS_JUMP_EN
        6'h02: begin npc = {npc[31:28], ir[25:0], 2'b00}; t = acc + 3; end
`endif
        default: begin done = 1; exp_halt = 1; end
      endcase
      mreg[0] = 32'h0;
      pc = npc;
    end
  endtask

  task automatic set_waits(input int mode);
    for (int i = 0; i < 1024; i++) waits[i] = (mode < 0) ? int'($urandom % 4) : mode;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) begin bmem[i] = prog[i]; mmem[i] = prog[i]; end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    tidx = 0; viol = 0;
    obs.delete();
    chk("rst_out", {mem_req, mem_we, halted, illegal, mem_addr, mem_wdata, pc_dbg},
        {4'b0, 64'h0, RST_PC});
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic run(input string nm, input int max_tx);
    int n, m;
    model_run(max_tx);
    do_reset();
    n = 0;
    while (n < 2000 && !(obs.size() >= expq.size() && (!exp_halt || halted))) begin
      @(negedge CLK); n++;
    end
    chk({nm, "_done"}, n < 2000, 1);
    if (exp_halt) begin
      repeat (4) @(negedge CLK);
      chk({nm, "_ntx"}, obs.size(), expq.size());
      chk({nm, "_halt"}, {halted, illegal, mem_req}, 3'b110);
    end
    chk({nm, "_stable"}, viol, 0);
    m = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_tx%0d", nm, i), {obs[i].we, obs[i].addr, obs[i].wdata},
          {expq[i].we, expq[i].addr, expq[i].wdata});
      chk($sformatf("%s_tm%0d", nm, i), {32'(obs[i].cyc), obs[i].pc},
          {32'(expq[i].cyc), expq[i].pc});
    end
  endtask

  task automatic gen_random();
    logic [4:0] rs, rt, rd;
    logic [5:0] fl [5];
    int k;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < 32; i++) prog[i] = ILL;
    for (int i = 0; i < 20; i++) begin
      k = $urandom % 14;
      rs = 5'($urandom % 8); rt = 5'($urandom % 8); rd = 5'($urandom % 8);
      if (k < 2)       prog[i] = {6'h23, 5'd0, rt, 16'(32'h200 + 4 * ($urandom % 64))};
      else if (k < 4)  prog[i] = {6'h2B, 5'd0, rt, 16'(32'h200 + 4 * ($urandom % 64))};
      else if (k < 8)  prog[i] = {6'h00, rs, rt, rd, 5'd0, fl[$urandom % 5]};
      else if (k < 11) prog[i] = {6'h08, rs, rt, 16'($urandom)};
      else if (k < 13) prog[i] = {6'h04, rs, rt, 16'($urandom % 3)};
      else             prog[i] = {6'h02, 26'(i + 2 + $urandom % 3)};
    end
    for (int i = 1; i < 8; i++) prog[19 + i] = {6'h2B, 5'd0, 5'(i), 16'(32'h2C0 + 4 * i)};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    for (int i = 32; i < 256; i++) begin bmem[i] = $urandom; mmem[i] = bmem[i]; end
    bmem[128] = 32'h1234_5678; mmem[128] = 32'h1234_5678;

    // Directed: lw, addi -1 / sw, register init, j to 0x40, slt signed, sub wrap.
    for (int i = 0; i < 32; i++) prog[i] = ILL;
    prog[0] = {6'h23, 5'd0, 5'd1, 16'h0200};
    prog[1] = {6'h08, 5'd0, 5'd2, 16'hFFFF};
    prog[2] = {6'h2B, 5'd0, 5'd2, 16'h0208};
    prog[3] = {6'h2B, 5'd0, 5'd1, 16'h020C};
    for (int i = 3; i < 8; i++) prog[i + 1] = {6'h08, 5'd0, 5'(i), 16'($urandom)};
    prog[9]  = 32'h0800_0010;
    prog[16] = {6'h00, 5'd2, 5'd0, 5'd4, 5'd0, 6'h2A};
    prog[17] = {6'h2B, 5'd0, 5'd4, 16'h0210};
    prog[18] = {6'h00, 5'd0, 5'd1, 5'd5, 5'd0, 6'h22};
    prog[19] = {6'h2B, 5'd0, 5'd5, 16'h0214};
    load_prog(); set_waits(0); spur_en = 0;
    run("basic", 1000);

    // Every access stretched by three wait states.
    for (int i = 0; i < 32; i++) prog[i] = ILL;
    prog[0] = {6'h23, 5'd0, 5'd6, 16'h0200};
    prog[1] = {6'h2B, 5'd0, 5'd6, 16'h0218};
    load_prog(); set_waits(3);
    run("wait3", 1000);

    // Unlisted R-type funct halts; reset afterwards must refetch RESET_PC.
    for (int i = 0; i < 32; i++) prog[i] = ILL;
    prog[0] = {6'h08, 5'd0, 5'd0, 16'h0055};
    prog[1] = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    load_prog(); set_waits(0);
    run("badfunct", 1000);

    // beq r0,r0,-1 spins at 0x10; then reset in the middle of a request.
    for (int i = 0; i < 32; i++) prog[i] = ILL;
    for (int i = 0; i < 4; i++) prog[i] = {6'h08, 5'd0, 5'd0, 16'h0005};
    prog[4] = {6'h04, 5'd0, 5'd0, 16'hFFFF};
    load_prog(); set_waits(-1);
    run("loop", 16);
    for (int i = 0; i < 10 && !mem_req; i++) begin @(posedge CLK); #2; end
    RST = 1'b1;
    #1;
    chk("rst_async", {mem_req, mem_we, halted, illegal}, 4'b0);

    // Register file must survive that reset: dump r1..r7.
    for (int i = 0; i < 32; i++) prog[i] = ILL;
    for (int i = 1; i < 8; i++) prog[i - 1] = {6'h2B, 5'd0, 5'(i), 16'(32'h2A0 + 4 * i)};
    load_prog(); set_waits(-1); spur_en = 1;
    run("keep_rf", 1000);

    for (int r = 0; r < 6; r++) begin
      gen_random(); load_prog(); set_waits(-1);
      run($sformatf("rand%0d", r), 1000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
